// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - ID/EX, forwarding and EX/MEM signal bundle for ex_mem_stage
interface ex_mem_stage_if #(
  parameter int DW = 32
);
  logic [5:0]    opcode_ex;
  logic          data_read_ex;
  logic          data_write_ex;
  logic          reg_write_ex;
  logic          wb_src_ex;
  logic          slt_inst_ex;
  logic          wr_sel_ex;
  logic          alu_src_ex;
  logic [3:0]    alu_ctrl_ex;
  logic [DW-1:0] rd1_ex;
  logic [DW-1:0] rd2_ex;
  logic [DW-1:0] imm_ex;
  logic [4:0]    rs_ex;
  logic [4:0]    rt_ex;
  logic [4:0]    rd_ex;

  logic          mem_reg_write;
  logic [4:0]    mem_wr_reg;
  logic [DW-1:0] mem_fwd_data;
  logic          wb_reg_write;
  logic [4:0]    wb_wr_reg;
  logic [DW-1:0] wb_fwd_data;

  logic          ex_busy;
  logic [5:0]    opcode_mem;
  logic          data_read_mem;
  logic          data_write_mem;
  logic          reg_write_mem;
  logic          wb_src_mem;
  logic [DW-1:0] alu_result_mem;
  logic [DW-1:0] store_data_mem;
  logic [4:0]    wr_reg_mem;

  modport master (
    output opcode_ex, data_read_ex, data_write_ex, reg_write_ex, wb_src_ex,
           slt_inst_ex, wr_sel_ex, alu_src_ex, alu_ctrl_ex,
           rd1_ex, rd2_ex, imm_ex, rs_ex, rt_ex, rd_ex,
           mem_reg_write, mem_wr_reg, mem_fwd_data,
           wb_reg_write, wb_wr_reg, wb_fwd_data,
    input  ex_busy, opcode_mem, data_read_mem, data_write_mem, reg_write_mem,
           wb_src_mem, alu_result_mem, store_data_mem, wr_reg_mem
  );

  modport slave (
    input  opcode_ex, data_read_ex, data_write_ex, reg_write_ex, wb_src_ex,
           slt_inst_ex, wr_sel_ex, alu_src_ex, alu_ctrl_ex,
           rd1_ex, rd2_ex, imm_ex, rs_ex, rt_ex, rd_ex,
           mem_reg_write, mem_wr_reg, mem_fwd_data,
           wb_reg_write, wb_wr_reg, wb_fwd_data,
    output ex_busy, opcode_mem, data_read_mem, data_write_mem, reg_write_mem,
           wb_src_mem, alu_result_mem, store_data_mem, wr_reg_mem
  );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - execute stage with operand forwarding and EX/MEM register
// EX_MUL_EN builds the iterative shift-add multiplier and its ex_busy stall.
module ex_mem_stage #(
  parameter int DW         = 32,
  parameter int MUL_CYCLES = 32
) (
  input logic           clk,
  input logic           reset,
  ex_mem_stage_if.slave bus
);
  logic [DW-1:0] op_a;
  logic [DW-1:0] fwd_b;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_y;
  logic [4:0]    wr_reg;
  logic          ex_busy;

  // MEM is the younger producer, so it wins over WB; r0 is never forwarded
  always_comb begin
    op_a = bus.rd1_ex;
    if (bus.mem_reg_write && (bus.mem_wr_reg != 5'd0) && (bus.mem_wr_reg == bus.rs_ex))
      op_a = bus.mem_fwd_data;
    else if (bus.wb_reg_write && (bus.wb_wr_reg != 5'd0) && (bus.wb_wr_reg == bus.rs_ex))
      op_a = bus.wb_fwd_data;
  end

  always_comb begin
    fwd_b = bus.rd2_ex;
    if (bus.mem_reg_write && (bus.mem_wr_reg != 5'd0) && (bus.mem_wr_reg == bus.rt_ex))
      fwd_b = bus.mem_fwd_data;
    else if (bus.wb_reg_write && (bus.wb_wr_reg != 5'd0) && (bus.wb_wr_reg == bus.rt_ex))
      fwd_b = bus.wb_fwd_data;
  end

  assign op_b   = bus.alu_src_ex ? bus.imm_ex : fwd_b;
  assign wr_reg = bus.wr_sel_ex ? bus.rd_ex : bus.rt_ex;

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;
  localparam int CW = $clog2(MUL_CYCLES + 1);

  mul_state_t    mul_state;
  logic [CW-1:0] mul_cnt;
  logic [DW-1:0] mul_acc;
  logic [DW-1:0] mul_mcand;
  logic [DW-1:0] mul_mplier;
  logic          mul_req;

  assign mul_req = (bus.alu_ctrl_ex == 4'b1000) && !bus.slt_inst_ex;

  // Operands are captured on entry so later forwarding changes cannot disturb the product
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_state  <= MUL_IDLE;
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
    end else begin
      case (mul_state)
        MUL_IDLE: begin
          if (mul_req) begin
            mul_state  <= MUL_RUN;
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= op_a;
            mul_mplier <= op_b;
          end
        end
        MUL_RUN: begin
          if (mul_mplier[0])
            mul_acc <= mul_acc + mul_mcand;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          if (mul_cnt == CW'(MUL_CYCLES - 1)) begin
            mul_state <= MUL_DONE;
            mul_cnt   <= '0;
          end else begin
            mul_cnt <= mul_cnt + 1'b1;
          end
        end
        MUL_DONE: mul_state <= MUL_IDLE;
        default:  mul_state <= MUL_IDLE;
      endcase
    end
  end

  assign ex_busy = reset && (((mul_state == MUL_IDLE) && mul_req) || (mul_state == MUL_RUN));
`else
  localparam int unused_mul_cycles = MUL_CYCLES;
  assign ex_busy = 1'b0;
`endif

  assign bus.ex_busy = ex_busy;

  always_comb begin
    alu_y = '0;
    if (bus.slt_inst_ex) begin
      alu_y = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
    end else begin
      case (bus.alu_ctrl_ex)
        4'b0000: alu_y = op_a & op_b;
        4'b0001: alu_y = op_a | op_b;
        4'b0010: alu_y = op_a + op_b;
        4'b0110: alu_y = op_a - op_b;
        4'b0111: alu_y = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        4'b1100: alu_y = ~(op_a | op_b);
`ifdef EX_MUL_EN
        4'b1000: alu_y = mul_acc;
`endif
        default: alu_y = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.opcode_mem     <= '0;
      bus.data_read_mem  <= 1'b0;
      bus.data_write_mem <= 1'b0;
      bus.reg_write_mem  <= 1'b0;
      bus.wb_src_mem     <= 1'b0;
      bus.alu_result_mem <= '0;
      bus.store_data_mem <= '0;
      bus.wr_reg_mem     <= '0;
    end else if (ex_busy) begin
      bus.opcode_mem     <= '0;
      bus.data_read_mem  <= 1'b0;
      bus.data_write_mem <= 1'b0;
      bus.reg_write_mem  <= 1'b0;
      bus.wb_src_mem     <= 1'b0;
      bus.alu_result_mem <= '0;
      bus.store_data_mem <= '0;
      bus.wr_reg_mem     <= '0;
    end else begin
      bus.opcode_mem     <= bus.opcode_ex;
      bus.data_read_mem  <= bus.data_read_ex;
      bus.data_write_mem <= bus.data_write_ex;
      bus.reg_write_mem  <= bus.reg_write_ex;
      bus.wb_src_mem     <= bus.wb_src_ex;
      bus.alu_result_mem <= alu_y;
      bus.store_data_mem <= fwd_b;
      bus.wr_reg_mem     <= wr_reg;
    end
  end
endmodule
